// File: rtl/cfg_reg_pkg.sv
// Shared address map and FSM state type for the config register arbiter.
package cfg_reg_pkg;

  localparam logic [6:0] ADDR_OUT_LO    = 7'h00;
  localparam logic [6:0] ADDR_OUT_HI    = 7'h01;
  localparam logic [6:0] ADDR_PWM_LO    = 7'h02;
  localparam logic [6:0] ADDR_PWM_HI    = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;
  localparam logic [6:0] MAX_VALID_ADDR = 7'd4;
  localparam logic [6:0] ADDR_LOCK      = 7'h7F;

  typedef enum logic [0:0] {
    StIdle,
    StExec
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the loser on every handshake.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       hs,
  output logic [1:0] grant
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (hs) begin
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/cfg_reg_arbiter.sv
// Two-requester arbiter in front of five 8-bit config registers at 0x00-0x04.
// Optional build macro CFG_ARB_LOCK_EN adds a requester-0-owned write lock at 0x7F.
module cfg_reg_arbiter
  import cfg_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_write,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_write,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_id,
  output logic       err
);

  arb_state_e state_q, state_d;
  logic [1:0] grant;
  logic       hs;
  logic       exec;

  logic       cap_write_q;
  logic       cap_id_q;
  logic [6:0] cap_addr_q;
  logic [7:0] cap_wdata_q;

  logic [7:0] out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;

  logic       rd_valid_q, rd_id_q, err_q;
  logic [7:0] rd_data_q;

  logic       addr_reg, addr_lock, wr_blocked;
  logic       reg_we, resp_err, rd_resp;
  logic [7:0] read_val;

`ifdef CFG_ARB_LOCK_EN
  logic lock_q, lock_we;
`endif

  assign req0_ready = (state_q == StIdle) && grant[0];
  assign req1_ready = (state_q == StIdle) && grant[1];
  assign hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign exec       = (state_q == StExec);
  assign rd_resp    = exec && !cap_write_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid ({req1_valid, req0_valid}),
    .hs    (hs),
    .grant (grant)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (hs) state_d = StExec;
      StExec:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_write_q <= 1'b0;
      cap_id_q    <= 1'b0;
      cap_addr_q  <= 7'h00;
      cap_wdata_q <= 8'h00;
    end else if (hs) begin
      cap_id_q    <= grant[1];
      cap_write_q <= grant[1] ? req1_write : req0_write;
      cap_addr_q  <= grant[1] ? req1_addr  : req0_addr;
      cap_wdata_q <= grant[1] ? req1_wdata : req0_wdata;
    end
  end

  assign addr_reg = (cap_addr_q <= MAX_VALID_ADDR);
`ifdef CFG_ARB_LOCK_EN
  assign addr_lock  = (cap_addr_q == ADDR_LOCK);
  // Requester 1 never owns the lock and is fenced off the registers while it is set
  assign wr_blocked = cap_id_q && (addr_lock || lock_q);
`else
  assign addr_lock  = 1'b0;
  assign wr_blocked = 1'b0;
`endif

  always_comb begin
    reg_we   = 1'b0;
    resp_err = 1'b0;
    read_val = 8'h00;
`ifdef CFG_ARB_LOCK_EN
    lock_we  = 1'b0;
`endif
    case (cap_addr_q)
      ADDR_OUT_LO:   read_val = out_lo_q;
      ADDR_OUT_HI:   read_val = out_hi_q;
      ADDR_PWM_LO:   read_val = pwm_lo_q;
      ADDR_PWM_HI:   read_val = pwm_hi_q;
      ADDR_PWM_DUTY: read_val = duty_q;
`ifdef CFG_ARB_LOCK_EN
      ADDR_LOCK:     read_val = {7'b0, lock_q};
`endif
      default:       read_val = 8'h00;
    endcase
    if (exec) begin
      if (!(addr_reg || addr_lock)) begin
        resp_err = 1'b1;
      end else if (cap_write_q) begin
        if (wr_blocked) begin
          resp_err = 1'b1;
        end else if (addr_reg) begin
          reg_we = 1'b1;
        end
`ifdef CFG_ARB_LOCK_EN
        else begin
          lock_we = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_lo_q <= 8'h00;
      out_hi_q <= 8'h00;
      pwm_lo_q <= 8'h00;
      pwm_hi_q <= 8'h00;
      duty_q   <= 8'h00;
    end else if (reg_we) begin
      case (cap_addr_q)
        ADDR_OUT_LO:   out_lo_q <= cap_wdata_q;
        ADDR_OUT_HI:   out_hi_q <= cap_wdata_q;
        ADDR_PWM_LO:   pwm_lo_q <= cap_wdata_q;
        ADDR_PWM_HI:   pwm_hi_q <= cap_wdata_q;
        ADDR_PWM_DUTY: duty_q   <= cap_wdata_q;
        default: ;
      endcase
    end
  end

`ifdef CFG_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (lock_we) begin
      lock_q <= cap_wdata_q[0];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_id_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_resp;
      rd_data_q  <= rd_resp ? read_val : 8'h00;
      err_q      <= resp_err;
      if (rd_resp) rd_id_q <= cap_id_q;
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign rd_valid        = rd_valid_q;
  assign rd_data         = rd_data_q;
  assign rd_id           = rd_id_q;
  assign err             = err_q;

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Scoreboard bench for cfg_reg_arbiter: drivers push hand-computed responses,
// a monitor pops and compares whenever rd_valid or err is presented.
module tb_cfg_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_write = 1'b0;
  logic [6:0] req0_addr = 7'h00;
  logic [7:0] req0_wdata = 8'h00;
  logic       req1_valid = 1'b0, req1_write = 1'b0;
  logic [6:0] req1_addr = 7'h00;
  logic [7:0] req1_wdata = 8'h00;
  logic       req0_ready, req1_ready;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
  logic       rd_valid, rd_id, err;
  logic [7:0] rd_data;

  cfg_reg_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0_valid      (req0_valid),
    .req0_ready      (req0_ready),
    .req0_write      (req0_write),
    .req0_addr       (req0_addr),
    .req0_wdata      (req0_wdata),
    .req1_valid      (req1_valid),
    .req1_ready      (req1_ready),
    .req1_write      (req1_write),
    .req1_addr       (req1_addr),
    .req1_wdata      (req1_wdata),
    .en_reg_out_7_0  (out_lo),
    .en_reg_out_15_8 (out_hi),
    .en_reg_pwm_7_0  (pwm_lo),
    .en_reg_pwm_15_8 (pwm_hi),
    .pwm_duty_cycle  (duty),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .rd_id           (rd_id),
    .err             (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rd;
    logic [7:0] data;
    logic       id;
    logic       err;
    int         cyc;
  } resp_t;

  resp_t exp_q[$];
  int    hs_id[$];
  int    hs_cyc[$];
  int    w0, w1, wm;
  logic  h0, h1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && (rd_valid || err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", int'({rd_valid, err}), 0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_valid", int'(rd_valid), int'(e.rd));
        check("resp_err", int'(err), int'(e.err));
        check("resp_cycle", cyc, e.cyc);
        if (e.rd) begin
          check("resp_data", int'(rd_data), int'(e.data));
          check("resp_id", int'(rd_id), int'(e.id));
        end else begin
          check("resp_data_idle", int'(rd_data), 0);
        end
      end
    end
  end

  // Handshake logger
  always @(negedge clk) begin
    if (rst_n) begin
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (h0 || h1) begin
        check("one_ready", int'(req0_ready && req1_ready), 0);
        hs_id.push_back(h1 ? 1 : 0);
        hs_cyc.push_back(cyc);
      end
    end
  end

  // Call just after a rising edge; returns just after the handshake edge.
  task automatic drive(input bit id, input bit wr, input logic [6:0] a, input logic [7:0] d,
                       input bit exp_err, input logic [7:0] exp_data, output int waited);
    bit    hs = 1'b0;
    resp_t e;
    waited = 0;
    if (id) begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = d;
    end
    while (!hs && waited < 20) begin
      @(negedge clk);
      waited++;
      hs = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
    end
    if (!hs) check("handshake_timeout", waited, 0);
    if (hs && (!wr || exp_err)) begin
      e.rd   = !wr;
      e.data = wr ? 8'h00 : exp_data;
      e.id   = id;
      e.err  = exp_err;
      e.cyc  = cyc + 2;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int exp_ids[4];
    exp_ids = '{0, 1, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_lo", int'(out_lo), 0);
    check("rst_out_hi", int'(out_hi), 0);
    check("rst_pwm_lo", int'(pwm_lo), 0);
    check("rst_pwm_hi", int'(pwm_hi), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_resp", int'({rd_valid, rd_data, rd_id, err}), 0);
    rst_n = 1'b1;

    // Write lands one edge after the handshake
    drive(0, 1, 7'h04, 8'hA5, 0, 8'h00, w0);
    check("first_grant_latency", w0, 1);
    check("duty_before_exec", int'(duty), 0);
    @(posedge clk); #1;
    check("duty_after_exec", int'(duty), 'hA5);
    drive(1, 0, 7'h04, 8'h00, 0, 8'hA5, w1);

    // Both requesters saturating: grants alternate, one handshake every 2 cycles
    hs_id.delete();
    hs_cyc.delete();
    fork
      begin
        drive(0, 1, 7'h00, 8'h11, 0, 8'h00, w0);
        drive(0, 1, 7'h00, 8'h11, 0, 8'h00, w0);
      end
      begin
        drive(1, 1, 7'h01, 8'h22, 0, 8'h00, w1);
        drive(1, 1, 7'h01, 8'h22, 0, 8'h00, w1);
      end
    join
    check("burst_count", hs_id.size(), 4);
    if (hs_id.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("burst_grant_%0d", i), hs_id[i], exp_ids[i]);
        if (i > 0) check($sformatf("burst_gap_%0d", i), hs_cyc[i] - hs_cyc[i-1], 2);
      end
    end
    @(posedge clk); #1;
    check("burst_out_lo", int'(out_lo), 'h11);
    check("burst_out_hi", int'(out_hi), 'h22);

    // Out-of-range address
    drive(1, 1, 7'h05, 8'hFF, 1, 8'h00, w1);
    @(posedge clk); #1;
    check("bad_wr_regs", int'({out_lo, out_hi, pwm_lo, pwm_hi, duty}), 'h1122_0000_A5);
    drive(0, 0, 7'h05, 8'h00, 1, 8'h00, w0);
`ifdef CFG_ARB_LOCK_EN
    drive(0, 0, 7'h7F, 8'h00, 0, 8'h00, w0);
`else
    drive(0, 0, 7'h7F, 8'h00, 1, 8'h00, w0);
`endif

    // One-cycle req0 pulse while req1 holds priority
    hs_id.delete();
    fork
      drive(1, 0, 7'h00, 8'h00, 0, 8'h11, w1);
      begin
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 7'h00; req0_wdata = 8'h99;
        @(posedge clk); #1;
        req0_valid = 1'b0;
      end
    join
    repeat (2) @(posedge clk); #1;
    check("pulse_hs_count", hs_id.size(), 1);
    if (hs_id.size() == 1) check("pulse_hs_id", hs_id[0], 1);
    check("pulse_out_lo", int'(out_lo), 'h11);

`ifdef CFG_ARB_LOCK_EN
    drive(0, 1, 7'h7F, 8'h01, 0, 8'h00, w0);
    drive(1, 1, 7'h00, 8'h55, 1, 8'h00, w1);
    @(posedge clk); #1;
    check("locked_out_lo", int'(out_lo), 'h11);
    drive(1, 1, 7'h7F, 8'h00, 1, 8'h00, w1);
    drive(1, 0, 7'h7F, 8'h00, 0, 8'h01, w1);
    drive(0, 1, 7'h00, 8'h55, 0, 8'h00, w0);
    @(posedge clk); #1;
    check("owner_out_lo", int'(out_lo), 'h55);
    drive(1, 0, 7'h00, 8'h00, 0, 8'h55, w1);
`else
    drive(0, 1, 7'h7F, 8'h01, 1, 8'h00, w0);
`endif

    // Reset while the write is in flight
    drive(0, 1, 7'h02, 8'h3C, 0, 8'h00, w0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("inflight_pwm_lo", int'(pwm_lo), 0);
    check("inflight_resp", int'({rd_valid, err}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 0, 7'h02, 8'h00, 0, 8'h00, w1);
    check("post_rst_grant_latency", w1, 1);
    check("post_rst_duty", int'(duty), 0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cfg_reg_arbiter.md
CFG_REG_ARBITER -- requirements
Module: cfg_reg_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports req0_valid/req1_valid  input  1  each requester's transaction request.
REQ-004 SHALL have ports req0_ready/req1_ready  output  1  grant/accept for each requester.
REQ-005 SHALL have ports reqN_write  input  1  per requester: 1=write, 0=read.
REQ-006 SHALL have ports reqN_addr  input  7  per requester: register address.
REQ-007 SHALL have ports reqN_wdata  input  8  per requester: write data.
REQ-008 SHALL have outputs en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  8 each  config registers at addresses 0x00-0x04.
REQ-009 SHALL have outputs rd_valid (1), rd_data (8) and rd_id (1): read response, data, and owning requester.
REQ-010 SHALL have output err  1  one-cycle pulse on a rejected transaction.

Function
REQ-011 SHALL implement FSM states IDLE and EXEC.
REQ-012 In IDLE, SHALL drive reqN_ready combinationally as (state==IDLE && grant==N); at most one ready high per cycle.
REQ-013 Handshake (valid&&ready at edge N) SHALL capture write/addr/wdata/id and move the FSM to EXEC; EXEC SHALL always return to IDLE at edge N+1.
REQ-014 A write SHALL update the target register at edge N+1; an accepted transaction SHALL never be aborted by later requests.
REQ-015 A read SHALL assert rd_valid for exactly one cycle after edge N+1, with rd_data = register value and rd_id = captured id.
REQ-016 Sustained throughput SHALL be one transaction per 2 cycles.
REQ-017 Address > 0x04 (except REQ-025) SHALL change no register; a read SHALL return rd_data=0x00 with rd_valid; err SHALL pulse in the same cycle as that response slot.
REQ-018 Grant SHALL be 2-way round-robin: a single valid requester wins; when both are valid, the requester pointed to by the priority pointer wins.
REQ-019 After each handshake, the pointer SHALL point to the non-granted requester.
REQ-020 Deasserting valid before ready SHALL be legal; no state change SHALL result.
REQ-021 Outside their pulse cycle, rd_valid, rd_data and err SHALL be 0.

Reset
REQ-022 rst_n low SHALL asynchronously force state=IDLE, all five registers=0x00, pointer=requester 0, rd_valid/rd_data/rd_id/err=0 and the lock bit=0.
REQ-023 Reset asserted while in EXEC SHALL discard the in-flight transaction: no write, no response.
REQ-024 After rst_n deasserts, the first grant SHALL be possible on the next rising edge.

Configuration
REQ-025 Macro CFG_ARB_LOCK_EN: when defined, address 0x7F SHALL be a lock register (bit0, readable); while lock=1, writes from requester 1 to 0x00-0x04 SHALL be dropped with an err pulse, and reads SHALL be unaffected. Only requester 0 SHALL be able to write 0x7F; a requester-1 write to 0x7F SHALL be dropped with err.
REQ-026 Without CFG_ARB_LOCK_EN, there SHALL be no lock logic, and 0x7F SHALL be treated as invalid per REQ-017.

Structure
REQ-027 Package cfg_reg_pkg SHALL hold the address constants ADDR_OUT_LO..ADDR_PWM_DUTY (0x00-0x04), MAX_VALID_ADDR=4, ADDR_LOCK=0x7F and the FSM state typedef.
REQ-028 Grant and pointer logic SHALL be in sub-module rr_arb2 (inputs: valids, handshake strobe; output: one-hot grant).

Verification
REQ-029 Reset, then req0 write 0x04/0xA5 -> pwm_duty_cycle=0xA5 one edge after handshake; req1 read 0x04 -> rd_valid, rd_data=0xA5, rd_id=1.
REQ-030 Both requesters valid continuously with writes 0x00/0x11 (req0) and 0x01/0x22 (req1) -> grants alternate 0,1,0,1, first grant to req0; a handshake occurs every 2 cycles.
REQ-031 req1 write 0x05/0xFF -> err pulse, all registers unchanged; req0 read 0x05 -> rd_data=0x00 and err.
REQ-032 Assert rst_n low during EXEC of a write 0x02/0x3C -> en_reg_pwm_7_0 stays 0x00 and no rd_valid or err.
REQ-033 With CFG_ARB_LOCK_EN: req0 write 0x7F/0x01, then req1 write 0x00/0x55 -> err, en_reg_out_7_0 unchanged; req0 write 0x00/0x55 -> accepted.
REQ-034 req0_valid pulsed for one cycle while req1 holds the grant -> no req0 transaction and no state change.
